// File: rtl/extmem_port.sv
// extmem_port: word-addressed external-memory responder for the DMA port.
// DMA transactions are answered after a fixed read or write latency,
// followed by one GAP cycle in which requests are ignored. A host port
// can read or write the backing store while the responder sits in IDLE.
module extmem_port #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_DEPTH = 65536,
   parameter int READ_LAT  = 4,
   parameter int WRITE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request_extmem,
   input  logic              write_extmem,
   input  logic [ADDR_W-1:0] addr_extmem,
   input  logic [DATA_W-1:0] w_data,
   output logic              valid_extmem,
   output logic [DATA_W-1:0] data_extmem,
   output logic              busy,
   output logic              err_range,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count,
   input  logic              host_en,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack
);

   localparam int              IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);
   localparam logic [3:0]      RD_LOAD = 4'(READ_LAT - 1);
   localparam logic [3:0]      WR_LOAD = 4'(WRITE_LAT - 1);
   localparam logic [31:0]     CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Word address lies inside the backing store.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_X);
   endfunction

   // Array index of an in-range word address.
   function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
      return a[IDX_W-1:0];
   endfunction

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rcap_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic              busy_q;
   logic              err_q;
   logic [31:0]       rdc_q;
   logic [31:0]       wrc_q;
   logic [DATA_W-1:0] hrdata_q;
   logic              hack_q;

   logic              accept_s;
   logic              host_srv_s;
   logic              enter_resp_s;
   logic              cur_wr_s;
   logic [ADDR_W-1:0] cur_addr_s;
   logic [DATA_W-1:0] cur_data_s;
   logic [DATA_W-1:0] acc_rword_s;
   logic [DATA_W-1:0] host_rword_s;
   logic              mem_we_s;
   logic [IDX_W-1:0]  mem_widx_s;
   logic [DATA_W-1:0] mem_wdata_s;

   assign accept_s   = (state_q == ST_IDLE) && request_extmem;
   assign host_srv_s = (state_q == ST_IDLE) && !request_extmem && host_en;

   // Next-state and latency counter; flags the edge that enters RESP.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      enter_resp_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (request_extmem) begin
               cnt_d = write_extmem ? WR_LOAD : RD_LOAD;
               if (cnt_d == 4'd0) begin
                  state_d      = ST_RESP;
                  enter_resp_s = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d      = ST_RESP;
               enter_resp_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_GAP;
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Transaction fields: live inputs on the accept edge (LAT=1 case), latched copy afterwards.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_wr_s   = write_extmem;
         cur_addr_s = addr_extmem;
         cur_data_s = w_data;
      end else begin
         cur_wr_s   = wr_q;
         cur_addr_s = addr_q;
         cur_data_s = wdata_q;
      end
   end

   // Memory read words for the DMA accept capture and the host read; out of range reads as 0.
   always_comb begin
      acc_rword_s  = '0;
      host_rword_s = '0;
      if (in_range(addr_extmem)) begin
         acc_rword_s = mem_q[to_idx(addr_extmem)];
      end else begin
         acc_rword_s = '0;
      end
      if (in_range(host_addr)) begin
         host_rword_s = mem_q[to_idx(host_addr)];
      end else begin
         host_rword_s = '0;
      end
   end

   // Single memory write port shared by the DMA commit and the host write.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_widx_s  = to_idx(cur_addr_s);
      mem_wdata_s = cur_data_s;
      if (rst) begin
         mem_we_s = 1'b0;
      end else if (host_srv_s) begin
         mem_we_s    = host_we && in_range(host_addr);
         mem_widx_s  = to_idx(host_addr);
         mem_wdata_s = host_wdata;
      end else begin
         mem_we_s = enter_resp_s && cur_wr_s && in_range(cur_addr_s);
      end
   end

   // Backing store; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_widx_s] <= mem_wdata_s;
      end
   end

   // Control, response, counter and host registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rcap_q   <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         rdc_q    <= 32'd0;
         wrc_q    <= 32'd0;
         hrdata_q <= '0;
         hack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= enter_resp_s;
         busy_q  <= (state_d != ST_IDLE);
         hack_q  <= host_srv_s;
         if (accept_s) begin
            wr_q    <= write_extmem;
            addr_q  <= addr_extmem;
            wdata_q <= w_data;
            if (!write_extmem) begin
               rcap_q <= acc_rword_s;
            end
            if (!in_range(addr_extmem)) begin
               err_q <= 1'b1;
            end
         end
         if (enter_resp_s) begin
            if (cur_wr_s) begin
               if (wrc_q != CNT_MAX) begin
                  wrc_q <= wrc_q + 32'd1;
               end
            end else begin
               data_q <= (state_q == ST_IDLE) ? acc_rword_s : rcap_q;
               if (rdc_q != CNT_MAX) begin
                  rdc_q <= rdc_q + 32'd1;
               end
            end
         end
         if (host_srv_s && !host_we) begin
            hrdata_q <= host_rword_s;
         end
      end
   end

   assign valid_extmem = valid_q;
   assign data_extmem  = data_q;
   assign busy         = busy_q;
   assign err_range    = err_q;
   assign rd_count     = rdc_q;
   assign wr_count     = wrc_q;
   assign host_rdata   = hrdata_q;
   assign host_ack     = hack_q;

endmodule

// File: tb/tb_extmem_port.sv
// Directed testbench for extmem_port with default parameters
// (READ_LAT=4, WRITE_LAT=2, MEM_DEPTH=65536).
module tb_extmem_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        request_extmem;
   logic        write_extmem;
   logic [31:0] addr_extmem;
   logic [31:0] w_data;
   logic        valid_extmem;
   logic [31:0] data_extmem;
   logic        busy;
   logic        err_range;
   logic [31:0] rd_count;
   logic [31:0] wr_count;
   logic        host_en;
   logic        host_we;
   logic [31:0] host_addr;
   logic [31:0] host_wdata;
   logic [31:0] host_rdata;
   logic        host_ack;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   extmem_port dut (
      .clk            (clk),
      .rst            (rst),
      .request_extmem (request_extmem),
      .write_extmem   (write_extmem),
      .addr_extmem    (addr_extmem),
      .w_data         (w_data),
      .valid_extmem   (valid_extmem),
      .data_extmem    (data_extmem),
      .busy           (busy),
      .err_range      (err_range),
      .rd_count       (rd_count),
      .wr_count       (wr_count),
      .host_en        (host_en),
      .host_we        (host_we),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .host_rdata     (host_rdata),
      .host_ack       (host_ack)
   );

   always #5 clk = ~clk;

   // Advance one clock and sample just after the rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One DMA transaction: checks busy, the exact latency of the valid pulse and the GAP cycle.
   task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input bit keep);
      request_extmem = 1'b1;
      write_extmem   = wr;
      addr_extmem    = a;
      w_data         = d;
      tick;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("host_ack_while_busy", {31'd0, host_ack}, 32'd0);
      chk("valid_early", {31'd0, valid_extmem}, 32'd0);
      // Fields changing after accept must not matter.
      addr_extmem  = a ^ 32'h0000_0001;
      w_data       = ~d;
      write_extmem = ~wr;
      for (int i = 1; i < lat; i++) begin
         tick;
         chk("valid_early", {31'd0, valid_extmem}, 32'd0);
      end
      tick;
      chk("valid_at_lat", {31'd0, valid_extmem}, 32'd1);
      if (!keep) request_extmem = 1'b0;
      tick;
      chk("valid_in_gap", {31'd0, valid_extmem}, 32'd0);
      chk("busy_in_gap", {31'd0, busy}, 32'd1);
      chk("host_ack_in_gap", {31'd0, host_ack}, 32'd0);
      tick;
      chk("busy_back_idle", {31'd0, busy}, 32'd0);
      chk("host_ack_idle_entry", {31'd0, host_ack}, 32'd0);
   endtask

   // One host access serviced in IDLE; ack must pulse for exactly one cycle.
   task automatic host_acc(input logic we, input logic [31:0] a, input logic [31:0] d);
      host_en    = 1'b1;
      host_we    = we;
      host_addr  = a;
      host_wdata = d;
      tick;
      chk("host_ack_pulse", {31'd0, host_ack}, 32'd1);
      chk("host_busy", {31'd0, busy}, 32'd0);
      host_en = 1'b0;
      tick;
      chk("host_ack_drop", {31'd0, host_ack}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      request_extmem = 1'b0;
      write_extmem   = 1'b0;
      addr_extmem    = 32'd0;
      w_data         = 32'd0;
      host_en        = 1'b0;
      host_we        = 1'b0;
      host_addr      = 32'd0;
      host_wdata     = 32'd0;
      tick; tick; tick;
      chk("rst_valid", {31'd0, valid_extmem}, 32'd0);
      chk("rst_data", data_extmem, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err_range}, 32'd0);
      chk("rst_rdc", rd_count, 32'd0);
      chk("rst_wrc", wr_count, 32'd0);
      chk("rst_hrdata", host_rdata, 32'd0);
      chk("rst_hack", {31'd0, host_ack}, 32'd0);
      rst = 1'b0;
      tick;

      // Read latency.
      host_acc(1'b1, 32'd10, 32'hCAFE_0001);
      run_txn(1'b0, 32'd10, 32'd0, 4, 1'b0);
      chk("rd10_data", data_extmem, 32'hCAFE_0001);
      chk("rd10_rdc", rd_count, 32'd1);
      chk("rd10_wrc", wr_count, 32'd0);

      // Write then read back by DMA and by host.
      run_txn(1'b1, 32'd20, 32'h1234_5678, 2, 1'b0);
      chk("wr20_wrc", wr_count, 32'd1);
      chk("wr20_data_hold", data_extmem, 32'hCAFE_0001);
      run_txn(1'b0, 32'd20, 32'd0, 4, 1'b0);
      chk("rd20_data", data_extmem, 32'h1234_5678);
      chk("rd20_rdc", rd_count, 32'd2);
      host_acc(1'b0, 32'd20, 32'd0);
      chk("host_rd20", host_rdata, 32'h1234_5678);

      // Back-to-back: request held through GAP, accepted only once IDLE is re-entered.
      run_txn(1'b0, 32'd10, 32'd0, 4, 1'b1);
      chk("b2b_first_data", data_extmem, 32'hCAFE_0001);
      run_txn(1'b0, 32'd20, 32'd0, 4, 1'b0);
      chk("b2b_second_data", data_extmem, 32'h1234_5678);
      chk("b2b_rdc", rd_count, 32'd4);

      // Out-of-range read, sticky error.
      run_txn(1'b0, 32'd70000, 32'd0, 4, 1'b0);
      chk("oor_data", data_extmem, 32'd0);
      chk("oor_err", {31'd0, err_range}, 32'd1);
      chk("oor_rdc", rd_count, 32'd5);
      run_txn(1'b0, 32'd10, 32'd0, 4, 1'b0);
      chk("err_sticky", {31'd0, err_range}, 32'd1);
      chk("good_after_oor", data_extmem, 32'hCAFE_0001);

      // Out-of-range write is dropped (no alias onto the low address bits).
      host_acc(1'b1, 32'd4464, 32'h0000_0055);
      run_txn(1'b1, 32'd70000, 32'hAAAA_AAAA, 2, 1'b0);
      chk("oor_wr_wrc", wr_count, 32'd2);
      host_acc(1'b0, 32'd4464, 32'd0);
      chk("oor_wr_dropped", host_rdata, 32'h0000_0055);
      host_acc(1'b0, 32'd70000, 32'd0);
      chk("host_oor_rd", host_rdata, 32'd0);
      chk("host_cnt_untouched", rd_count, 32'd6);

      // Host/DMA collision: DMA wins, host served after return to IDLE.
      host_en   = 1'b1;
      host_we   = 1'b0;
      host_addr = 32'd10;
      run_txn(1'b0, 32'd20, 32'd0, 4, 1'b0);
      chk("coll_dma_data", data_extmem, 32'h1234_5678);
      tick;
      chk("coll_host_ack", {31'd0, host_ack}, 32'd1);
      chk("coll_host_data", host_rdata, 32'hCAFE_0001);
      host_en = 1'b0;
      tick;
      chk("coll_host_ack_once", {31'd0, host_ack}, 32'd0);
      chk("coll_rdc", rd_count, 32'd7);

      // Reset in WAIT of a write: nothing committed, state and counters cleared.
      host_acc(1'b1, 32'd30, 32'h0000_0000);
      request_extmem = 1'b1;
      write_extmem   = 1'b1;
      addr_extmem    = 32'd30;
      w_data         = 32'hDEAD_BEEF;
      tick;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst            = 1'b1;
      request_extmem = 1'b0;
      tick;
      chk("mid_rst_valid", {31'd0, valid_extmem}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_wrc", wr_count, 32'd0);
      chk("mid_rst_rdc", rd_count, 32'd0);
      chk("mid_rst_err", {31'd0, err_range}, 32'd0);
      chk("mid_rst_data", data_extmem, 32'd0);
      rst = 1'b0;
      tick;
      chk("post_rst_valid", {31'd0, valid_extmem}, 32'd0);
      tick;
      chk("post_rst_valid2", {31'd0, valid_extmem}, 32'd0);
      host_acc(1'b0, 32'd30, 32'd0);
      chk("mid_rst_mem30", host_rdata, 32'd0);
      chk("mem_survives_rst", dut.mem_q[10], 32'hCAFE_0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
